// File: rtl/keypad_bcd_encoder_if.sv
// Keypad-to-BCD link: raw key lines toward the encoder, encoded digit and status back.
// master drives key_in; slave is the encoder side.
interface keypad_bcd_encoder_if;
  logic [8:0] key_in;
  logic [3:0] bcd_out;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;

  modport master (
    output key_in,
    input  bcd_out,
    input  key_valid,
    input  key_held,
    input  multi_err
  );

  modport slave (
    input  key_in,
    output bcd_out,
    output key_valid,
    output key_held,
    output multi_err
  );
endinterface

// File: rtl/keypad_bcd_encoder.sv
// Synchronises, debounces and priority-encodes nine one-hot key lines into a BCD digit.
// Optional MULTI_KEY_ERR_EN rejects multi-key presses with a multi_err pulse instead.
module keypad_bcd_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_bcd_encoder_if.slave   kp
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StPressed,
    StRelease
  } state_e;

  state_e          r_state, w_state_d;
  logic [8:0]      r_sync [SYNC_STAGES];
  logic [8:0]      w_ks;
  logic [8:0]      r_snap, w_snap_d;
  logic [CntW-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic [3:0]      r_bcd, w_bcd_d;
  logic            r_valid, w_valid_d;
  logic            r_held, w_held_d;
  logic            w_reject;
`ifdef MULTI_KEY_ERR_EN
  logic            r_merr, w_merr_d;
`endif

  function automatic logic [3:0] encode(input logic [8:0] v);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) code = 4'(i + 1);
    end
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= kp.key_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_ks      = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = r_cnt + 1'b1;

  // More than one bit set iff clearing the lowest set bit leaves something.
`ifdef MULTI_KEY_ERR_EN
  assign w_reject = |(r_snap & (r_snap - 9'd1));
`else
  assign w_reject = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_snap_d  = r_snap;
    w_cnt_d   = r_cnt;
    w_bcd_d   = r_bcd;
    w_valid_d = 1'b0;
    w_held_d  = r_held;
`ifdef MULTI_KEY_ERR_EN
    w_merr_d  = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_ks != '0) begin
          w_snap_d  = w_ks;
          w_cnt_d   = CntW'(1);
          w_state_d = StDebounce;
        end
      end
      StDebounce: begin
        if (w_ks == '0) begin
          w_state_d = StIdle;
        end else if (w_ks != r_snap) begin
          w_snap_d = w_ks;
          w_cnt_d  = CntW'(1);
        end else if (r_cnt != CntMax) begin
          w_cnt_d = w_cnt_inc;
        end else if (w_reject) begin
`ifdef MULTI_KEY_ERR_EN
          w_merr_d  = 1'b1;
`endif
          w_cnt_d   = '0;
          w_state_d = StRelease;
        end else begin
          w_bcd_d   = encode(r_snap);
          w_valid_d = 1'b1;
          w_held_d  = 1'b1;
          w_state_d = StPressed;
        end
      end
      StPressed: begin
        if (w_ks != r_snap) begin
          w_cnt_d   = '0;
          w_state_d = StRelease;
        end
      end
      StRelease: begin
        // Release completes on the edge where the count would reach its limit.
        if (w_ks != '0) begin
          w_cnt_d = '0;
        end else if (w_cnt_inc == CntMax) begin
          w_cnt_d   = w_cnt_inc;
          w_held_d  = 1'b0;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_snap  <= '0;
      r_cnt   <= '0;
      r_bcd   <= 4'd0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_snap  <= w_snap_d;
      r_cnt   <= w_cnt_d;
      r_bcd   <= w_bcd_d;
      r_valid <= w_valid_d;
      r_held  <= w_held_d;
    end
  end

`ifdef MULTI_KEY_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) r_merr <= 1'b0;
    else     r_merr <= w_merr_d;
  end
  assign kp.multi_err = r_merr;
`else
  assign kp.multi_err = 1'b0;
`endif

  assign kp.bcd_out   = r_bcd;
  assign kp.key_valid = r_valid;
  assign kp.key_held  = r_held;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Directed bench for keypad_bcd_encoder with default parameters (latency 7 cycles).
module tb_keypad_bcd_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_bcd_encoder_if kp ();

  keypad_bcd_encoder #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_valid = 0;
  int n_merr  = 0;
  int n_heldc = 0;

  always @(posedge clk) begin
    if (kp.key_valid === 1'b1) n_valid <= n_valid + 1;
    if (kp.multi_err === 1'b1) n_merr  <= n_merr + 1;
    if (kp.key_held  === 1'b1) n_heldc <= n_heldc + 1;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  int v0, m0, h0;

  initial begin
    rst       = 1'b1;
    kp.key_in = 9'h000;
    step(2);
    check("rst_bcd", 32'(kp.bcd_out), 0);
    check("rst_valid", 32'(kp.key_valid), 0);
    check("rst_held", 32'(kp.key_held), 0);
    check("rst_merr", 32'(kp.multi_err), 0);
    rst = 1'b0;

    // Idle for 20 cycles: nothing may fire.
    v0 = n_valid; m0 = n_merr; h0 = n_heldc;
    step(20);
    check("idle_bcd", 32'(kp.bcd_out), 0);
    check("idle_valid_cnt", 32'(n_valid - v0), 0);
    check("idle_held_cnt", 32'(n_heldc - h0), 0);
    check("idle_merr_cnt", 32'(n_merr - m0), 0);

    // Digit 5: pulse exactly in cycle 7.
    v0 = n_valid;
    kp.key_in = 9'h010;
    step(6);
    check("d5_valid_c6", 32'(kp.key_valid), 0);
    step(1);
    check("d5_valid_c7", 32'(kp.key_valid), 1);
    check("d5_bcd", 32'(kp.bcd_out), 5);
    check("d5_held", 32'(kp.key_held), 1);
    step(1);
    check("d5_valid_c8", 32'(kp.key_valid), 0);
    step(12);
    check("d5_pulse_cnt", 32'(n_valid - v0), 1);
    kp.key_in = 9'h000;
    step(6);
    check("d5_held_rel6", 32'(kp.key_held), 1);
    step(1);
    check("d5_held_rel7", 32'(kp.key_held), 0);
    check("d5_bcd_hold", 32'(kp.bcd_out), 5);
    step(5);

    // Bouncing digit 3 never settles long enough.
    v0 = n_valid;
    for (int i = 0; i < 10; i++) begin
      kp.key_in = (i % 2 == 0) ? 9'h004 : 9'h000;
      step(2);
    end
    kp.key_in = 9'h000;
    step(5);
    check("bounce_valid_cnt", 32'(n_valid - v0), 0);
    check("bounce_bcd", 32'(kp.bcd_out), 5);
    check("bounce_held", 32'(kp.key_held), 0);

    // Digits 1 and 9 together.
    v0 = n_valid; m0 = n_merr;
    kp.key_in = 9'h101;
    step(20);
`ifdef MULTI_KEY_ERR_EN
    check("multi_valid_cnt", 32'(n_valid - v0), 0);
    check("multi_merr_cnt", 32'(n_merr - m0), 1);
    check("multi_bcd", 32'(kp.bcd_out), 5);
    check("multi_held", 32'(kp.key_held), 0);
`else
    check("multi_valid_cnt", 32'(n_valid - v0), 1);
    check("multi_merr_cnt", 32'(n_merr - m0), 0);
    check("multi_bcd", 32'(kp.bcd_out), 9);
    check("multi_held", 32'(kp.key_held), 1);
`endif
    kp.key_in = 9'h000;
    step(10);
    check("multi_rel_held", 32'(kp.key_held), 0);

    // Digit 2 then digit 8 with a one-cycle release glitch.
    v0 = n_valid;
    kp.key_in = 9'h002;
    step(7);
    check("d2_valid", 32'(kp.key_valid), 1);
    check("d2_bcd", 32'(kp.bcd_out), 2);
    step(3);
    kp.key_in = 9'h000;
    step(10);
    check("d2_rel_held", 32'(kp.key_held), 0);
    kp.key_in = 9'h080;
    step(7);
    check("d8_valid", 32'(kp.key_valid), 1);
    check("d8_bcd", 32'(kp.bcd_out), 8);
    step(3);
    kp.key_in = 9'h000;
    step(1);
    kp.key_in = 9'h080;
    step(10);
    check("d8_glitch_held", 32'(kp.key_held), 1);
    check("d8_glitch_bcd", 32'(kp.bcd_out), 8);
    kp.key_in = 9'h000;
    step(10);
    check("d8_rel_held", 32'(kp.key_held), 0);
    check("d2d8_pulse_cnt", 32'(n_valid - v0), 2);

    // Reset while digit 3 is pressed, key kept down afterwards.
    kp.key_in = 9'h004;
    step(10);
    check("d3_held", 32'(kp.key_held), 1);
    check("d3_bcd", 32'(kp.bcd_out), 3);
    rst = 1'b1;
    step(1);
    check("d3_rst_bcd", 32'(kp.bcd_out), 0);
    check("d3_rst_held", 32'(kp.key_held), 0);
    check("d3_rst_valid", 32'(kp.key_valid), 0);
    rst = 1'b0;
    step(6);
    check("d3_re_valid_c6", 32'(kp.key_valid), 0);
    check("d3_re_bcd_c6", 32'(kp.bcd_out), 0);
    step(1);
    check("d3_re_valid_c7", 32'(kp.key_valid), 1);
    check("d3_re_bcd", 32'(kp.bcd_out), 3);
    kp.key_in = 9'h000;
    step(10);
    check("d3_re_rel_held", 32'(kp.key_held), 0);

`ifdef MULTI_KEY_ERR_EN
    check("merr_total", 32'(n_merr), 1);
`else
    check("merr_total", 32'(n_merr), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/keypad_bcd_encoder.md
Name: keypad_bcd_encoder

Overview:
- Reverse direction of the BCD digit decoder: takes nine one-hot key lines (digits 1..9) and produces the 4-bit BCD code of the pressed key.
- Synchronises the raw key lines, debounces them, and priority-encodes the result.
- Emits a one-cycle valid strobe per debounced press and holds the last digit.
- Sits between the board push-buttons/keypad and the downstream display/accumulator logic.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a press or a release. Legal range 1..255.
- SYNC_STAGES, 2: depth of the input synchroniser flop chain. Legal range 2..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  9  raw key lines, active-high; bit i = digit i+1 (key_in[0] = 1, key_in[8] = 9).
- bcd_out  output  4  BCD code of the last accepted key, 4'd1..4'd9; 4'd0 = no key accepted since reset.
- key_valid  output  1  one-cycle pulse when a new press is accepted; bcd_out is already updated in that cycle.
- key_held  output  1  high from acceptance until the debounced release completes.
- multi_err  output  1  one-cycle pulse on a rejected multi-key press; constant 0 unless MULTI_KEY_ERR_EN is defined.

Behaviour:
- Reset (rst = 1 at a rising edge):
  - Synchroniser flops, snapshot register and counter cleared.
  - State forced to IDLE.
  - bcd_out = 4'd0; key_valid = 0; key_held = 0; multi_err = 0.
  - Reset overrides every other event in the same cycle, including mid-debounce and PRESSED.
- Synchroniser: key_in passes through SYNC_STAGES flops; ks denotes the synchronised vector. All logic below uses ks only.
- Counter: width clog2(DEBOUNCE_CYCLES + 1); it never wraps.
- State machine: four states, IDLE, DEBOUNCE, PRESSED, RELEASE.
- IDLE:
  - If ks != 0: snapshot <= ks, counter <= 1, go to DEBOUNCE.
  - Otherwise stay.
- DEBOUNCE:
  - ks == 0: go to IDLE.
  - ks != snapshot (nonzero): snapshot <= ks, counter <= 1, stay (restart).
  - ks == snapshot and counter < DEBOUNCE_CYCLES: counter + 1.
  - ks == snapshot and counter == DEBOUNCE_CYCLES: go to PRESSED.
- On the transition into PRESSED:
  - bcd_out <= encode(snapshot); key_valid = 1 for exactly that cycle; key_held <= 1.
  - The error path under MULTI_KEY_ERR_EN replaces this (see Optional Feature).
- PRESSED:
  - Stays while ks == snapshot.
  - Any change (release or a different pattern): counter <= 0, go to RELEASE.
- RELEASE:
  - ks == 0: counter + 1.
  - ks != 0: counter <= 0 (glitch restart).
  - When counter reaches DEBOUNCE_CYCLES: key_held <= 0, go to IDLE.
  - A new press is only accepted via IDLE, so holding or re-pressing never produces a second key_valid.
- Encode rule: highest-numbered asserted bit wins (9 over 8 … over 1).
  - Result is 4 bits, binary value = bit index + 1.
  - Never outputs 0 or values above 9.
- Latency: key_in stable from cycle 0 gives key_valid high in cycle SYNC_STAGES + DEBOUNCE_CYCLES + 1 (defaults: cycle 7).
- Release latency: key_held falls SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles after key_in returns to 0.
- Output hold: bcd_out holds its value through release and IDLE; it changes only on acceptance or reset.

Optional Feature:
- Macro: MULTI_KEY_ERR_EN.
- Defined: on the transition into PRESSED, if snapshot has more than one bit set:
  - no key_valid; bcd_out unchanged; key_held stays 0;
  - multi_err = 1 for that single cycle;
  - state goes directly to RELEASE with counter <= 0.
- Not defined:
  - multi-key presses are priority-encoded like single presses;
  - multi_err is tied to 0;
  - no popcount logic is synthesised.

Test Plan:
- Reset, key_in = 0 for 20 cycles -> bcd_out = 0, key_valid/key_held/multi_err never high.
- key_in = 9'h010 (digit 5) held 20 cycles, then 0 -> key_valid single pulse in cycle 7, bcd_out = 4'd5, key_held high until 7 cycles after release; exactly one pulse.
- key_in toggles 9'h004 / 0 every 2 cycles for 20 cycles -> no key_valid; bcd_out keeps previous value.
- key_in = 9'h101 (digits 1 and 9) held:
  - without macro -> bcd_out = 4'd9, one key_valid;
  - with MULTI_KEY_ERR_EN -> multi_err one pulse, no key_valid, bcd_out unchanged.
- Press 9'h002 accepted, release, press 9'h080 -> two key_valid pulses, bcd_out 4'd2 then 4'd8; 1-cycle release glitch during 9'h080 hold yields no extra pulse.
- Assert rst while in PRESSED with digit 3 held -> next cycle bcd_out = 0, key_held = 0; key still held after rst drops -> new key_valid 7 cycles later with bcd_out = 4'd3.
